hier_reg_responder: RTL and testbench

//   Register-access responder for a parameterised top/mid/bot register hierarchy.

---
 rtl/hier_reg_responder_if.sv | 25 ++
 rtl/hier_reg_responder.sv | 100 ++++++++++
 tb/tb_hier_reg_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hier_reg_responder_if.sv
// Request/response channel bundle between the config initiator and hier_reg_responder.
interface hier_reg_responder_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic [7:0]        err_cnt;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt
  );
endinterface

// File: rtl/hier_reg_responder.sv
// Register-access responder for a top/mid/bot register hierarchy; one transaction
// at a time over valid/ready request and response channels.
module hier_reg_responder #(
  parameter int unsigned P1     = 20,
  parameter int unsigned MID_N  = 3,
  parameter int unsigned BOT_N  = 3,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hier_reg_responder_if.slave  bus
);
  localparam int unsigned BOT_W  = (P1 == 20) ? 8 : (P1 == 10) ? 4 : 0;
  // Storage keeps a 1-bit width when the bot region is absent; it is never addressed then.
  localparam int unsigned BOT_SW = (BOT_W == 0) ? 1 : BOT_W;

  typedef enum logic {IDLE, RESP} state_t;

  state_t            r_state;
  logic              r_top;
  logic [3:0]        r_mid [MID_N];
  logic [BOT_SW-1:0] r_bot [BOT_N];
  logic [7:0]        r_rdata;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  int unsigned       w_addr;
  logic              w_hit;
  logic [7:0]        w_rdata;

  always_comb begin
    w_addr  = 32'(bus.req_addr);
    w_hit   = 1'b0;
    w_rdata = '0;
    if (w_addr == 0) begin
      w_hit   = 1'b1;
      w_rdata = {7'd0, r_top};
    end
    for (int unsigned i = 0; i < MID_N; i++) begin
      if (w_addr == i + 1) begin
        w_hit   = 1'b1;
        w_rdata = 8'(r_mid[i]);
      end
    end
    if (BOT_W != 0) begin
      for (int unsigned i = 0; i < BOT_N; i++) begin
        if (w_addr == MID_N + 1 + i) begin
          w_hit   = 1'b1;
          w_rdata = 8'(r_bot[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_top     <= 1'b0;
      r_mid     <= '{default: '0};
      r_bot     <= '{default: '0};
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_state <= RESP;
            r_err   <= !w_hit;
            r_rdata <= (bus.req_write || !w_hit) ? '0 : w_rdata;
            if (!w_hit && r_err_cnt != 8'hFF)
              r_err_cnt <= r_err_cnt + 8'd1;
            if (w_hit && bus.req_write) begin
              if (w_addr == 0)
                r_top <= bus.req_wdata[0];
              for (int unsigned i = 0; i < MID_N; i++)
                if (w_addr == i + 1)
                  r_mid[i] <= bus.req_wdata[3:0];
              if (BOT_W != 0)
                for (int unsigned i = 0; i < BOT_N; i++)
                  if (w_addr == MID_N + 1 + i)
                    r_bot[i] <= bus.req_wdata[BOT_SW-1:0];
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = rst_n && (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_hier_reg_responder.sv
// Scoreboard bench: three responders (P1=20/10/30) share one stimulus stream and are
// checked against a plain array model of the register map.
module tb_hier_reg_responder;
  localparam int MID_N  = 3;
  localparam int BOT_N  = 3;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              tb_req_valid = 1'b0;
  logic              tb_req_write = 1'b0;
  logic [ADDR_W-1:0] tb_req_addr  = '0;
  logic [7:0]        tb_req_wdata = '0;
  logic              tb_rsp_ready = 1'b0;

  hier_reg_responder_if #(.ADDR_W(ADDR_W)) if20 ();
  hier_reg_responder_if #(.ADDR_W(ADDR_W)) if10 ();
  hier_reg_responder_if #(.ADDR_W(ADDR_W)) if30 ();

  assign if20.req_valid = tb_req_valid;
  assign if20.req_write = tb_req_write;
  assign if20.req_addr  = tb_req_addr;
  assign if20.req_wdata = tb_req_wdata;
  assign if20.rsp_ready = tb_rsp_ready;
  assign if10.req_valid = tb_req_valid;
  assign if10.req_write = tb_req_write;
  assign if10.req_addr  = tb_req_addr;
  assign if10.req_wdata = tb_req_wdata;
  assign if10.rsp_ready = tb_rsp_ready;
  assign if30.req_valid = tb_req_valid;
  assign if30.req_write = tb_req_write;
  assign if30.req_addr  = tb_req_addr;
  assign if30.req_wdata = tb_req_wdata;
  assign if30.rsp_ready = tb_rsp_ready;

  hier_reg_responder #(.P1(20), .MID_N(MID_N), .BOT_N(BOT_N), .ADDR_W(ADDR_W))
    u_dut20 (.clk(clk), .rst_n(rst_n), .bus(if20.slave));
  hier_reg_responder #(.P1(10), .MID_N(MID_N), .BOT_N(BOT_N), .ADDR_W(ADDR_W))
    u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10.slave));
  hier_reg_responder #(.P1(30), .MID_N(MID_N), .BOT_N(BOT_N), .ADDR_W(ADDR_W))
    u_dut30 (.clk(clk), .rst_n(rst_n), .bus(if30.slave));

  logic [7:0] o_rd [3];
  logic       o_er [3];
  logic       o_rv [3];
  logic       o_rr [3];
  logic [7:0] o_ec [3];
  assign o_rd[0] = if20.rsp_rdata; assign o_rd[1] = if10.rsp_rdata; assign o_rd[2] = if30.rsp_rdata;
  assign o_er[0] = if20.rsp_err;   assign o_er[1] = if10.rsp_err;   assign o_er[2] = if30.rsp_err;
  assign o_rv[0] = if20.rsp_valid; assign o_rv[1] = if10.rsp_valid; assign o_rv[2] = if30.rsp_valid;
  assign o_rr[0] = if20.req_ready; assign o_rr[1] = if10.req_ready; assign o_rr[2] = if30.req_ready;
  assign o_ec[0] = if20.err_cnt;   assign o_ec[1] = if10.err_cnt;   assign o_ec[2] = if30.err_cnt;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: register contents as plain integers per configuration.
  typedef struct packed {
    logic [2:0][7:0] rd;
    logic [2:0]      er;
  } exp_t;
  exp_t q[$];

  int m_top [3];
  int m_mid [3][MID_N];
  int m_bot [3][BOT_N];
  int m_err [3];

  function automatic int bot_w(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_top[k] = 0;
      m_err[k] = 0;
      for (int i = 0; i < MID_N; i++) m_mid[k][i] = 0;
      for (int i = 0; i < BOT_N; i++) m_bot[k][i] = 0;
    end
    q.delete();
  endfunction

  function automatic void model_issue(input bit wr, input int addr, input int wd);
    exp_t e;
    int   rd;
    bit   er;
    for (int k = 0; k < 3; k++) begin
      rd = 0;
      er = 0;
      if (addr == 0) begin
        if (wr) m_top[k] = wd % 2; else rd = m_top[k];
      end else if (addr >= 1 && addr <= MID_N) begin
        if (wr) m_mid[k][addr-1] = wd % 16; else rd = m_mid[k][addr-1];
      end else if (bot_w(k) > 0 && addr > MID_N && addr <= MID_N + BOT_N) begin
        if (wr) m_bot[k][addr-MID_N-1] = wd % (1 << bot_w(k));
        else    rd = m_bot[k][addr-MID_N-1];
      end else begin
        er = 1;
        if (m_err[k] < 255) m_err[k]++;
      end
      e.rd[k] = 8'(rd);
      e.er[k] = er;
    end
    q.push_back(e);
  endfunction

  // Monitor: compare on every response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_rv[0] && tb_rsp_ready) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 0, 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          check("rsp_valid_agree", k, 32'(o_rv[k]), 32'd1);
          check("rsp_rdata", k, 32'(o_rd[k]), 32'(e.rd[k]));
          check("rsp_err", k, 32'(o_er[k]), 32'(e.er[k]));
        end
      end
    end
  end

  task automatic wait_ready();
    int budget;
    budget = 0;
    while (!o_rr[0] && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!o_rr[0]) check("req_ready_timeout", 0, 32'd0, 32'd1);
  endtask

  task automatic do_txn(input bit wr, input int addr, input int wd, input int hold);
    logic [7:0] cap_rd [3];
    logic       cap_er [3];
    wait_ready();
    tb_req_valid = 1'b1;
    tb_req_write = wr;
    tb_req_addr  = 4'(addr);
    tb_req_wdata = 8'(wd);
    tb_rsp_ready = (hold == 0);
    model_issue(wr, addr, wd);
    @(posedge clk); #1;
    tb_req_valid = 1'b0;
    tb_req_addr  = 4'($urandom);
    for (int k = 0; k < 3; k++) begin
      check("latency_rsp_valid", k, 32'(o_rv[k]), 32'd1);
      check("busy_req_ready", k, 32'(o_rr[k]), 32'd0);
      cap_rd[k] = o_rd[k];
      cap_er[k] = o_er[k];
    end
    for (int h = 0; h < hold; h++) begin
      // Requests offered while a response is pending must be ignored.
      tb_req_valid = 1'b1;
      tb_req_write = 1'($urandom);
      tb_req_addr  = 4'($urandom_range(0, 6));
      tb_req_wdata = 8'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check("hold_rsp_valid", k, 32'(o_rv[k]), 32'd1);
        check("hold_rsp_rdata", k, 32'(o_rd[k]), 32'(cap_rd[k]));
        check("hold_rsp_err", k, 32'(o_er[k]), 32'(cap_er[k]));
        check("hold_req_ready", k, 32'(o_rr[k]), 32'd0);
      end
      @(posedge clk); #1;
    end
    tb_req_valid = 1'b0;
    tb_rsp_ready = 1'b1;
    @(posedge clk); #1;
    tb_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("post_rsp_valid", k, 32'(o_rv[k]), 32'd0);
      check("post_req_ready", k, 32'(o_rr[k]), 32'd1);
      check("err_cnt", k, 32'(o_ec[k]), 32'(m_err[k]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("reset_req_ready_low", k, 32'(o_rr[k]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_req_ready", k, 32'(o_rr[k]), 32'd1);
      check("reset_rsp_valid", k, 32'(o_rv[k]), 32'd0);
      check("reset_rsp_rdata", k, 32'(o_rd[k]), 32'd0);
      check("reset_rsp_err", k, 32'(o_er[k]), 32'd0);
      check("reset_err_cnt", k, 32'(o_ec[k]), 32'd0);
    end

    do_txn(1, 0, 'hFF, 0);
    do_txn(0, 0, 0, 0);
    do_txn(1, 2, 'hAB, 0);
    do_txn(0, 2, 0, 0);
    do_txn(0, 1, 0, 0);
    do_txn(0, 3, 0, 0);
    do_txn(1, 4, 'hA5, 0);
    do_txn(0, 4, 0, 0);
    do_txn(0, 7, 0, 0);
    for (int i = 0; i < 300; i++) do_txn(1'($urandom), $urandom_range(7, 15), $urandom_range(0, 255), 0);
    do_txn(0, 2, 0, 3);

    // Reset while a write response is pending: response dropped, registers cleared.
    wait_ready();
    tb_req_valid = 1'b1;
    tb_req_write = 1'b1;
    tb_req_addr  = 4'd1;
    tb_req_wdata = 8'h07;
    tb_rsp_ready = 1'b0;
    @(posedge clk); #1;
    tb_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) check("pre_reset_rsp_valid", k, 32'(o_rv[k]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check("midreset_rsp_valid", k, 32'(o_rv[k]), 32'd0);
      check("midreset_req_ready", k, 32'(o_rr[k]), 32'd0);
      check("midreset_err_cnt", k, 32'(o_ec[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check("release_req_ready", k, 32'(o_rr[k]), 32'd1);
    do_txn(0, 1, 0, 0);

    for (int i = 0; i < 200; i++) begin
      do_txn(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    check("queue_drain", 0, 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
